// File: rtl/led_scan_driver_pkg.sv
// Shared definitions for the LED matrix scan driver.
//   scan_state_t  : scan FSM state encoding (IDLE, FETCH, SHOW)
//   PWM_STEPS     : PWM slots per displayed row
//   FETCH_CYCLES  : cycles spent reading one row from the frame RAM
//   GAMMA_LUT     : 16 x 4-bit brightness curve, entry i in bits [4i+3:4i]
//   onehot()      : 3-bit binary index to 8-bit one-hot (inverse of the
//                   one-hot to binary conversion on the light-pen write path)
//   gamma_lvl()   : GAMMA_LUT lookup
package led_scan_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int unsigned PWM_STEPS    = 16;
  localparam int unsigned FETCH_CYCLES = 9;

  // Index 15 in the top nibble down to index 0 in the bottom nibble:
  // {0,0,0,1,1,2,2,3,4,5,6,7,9,10,12,15}
  localparam logic [63:0] GAMMA_LUT = {
    4'd15, 4'd12, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
    4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [7:0] onehot(input logic [2:0] bin);
    onehot = 8'd1 << bin;
  endfunction

  function automatic logic [3:0] gamma_lvl(input logic [3:0] x);
    gamma_lvl = GAMMA_LUT[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/led_scan_driver_if.sv
// Read port between the scan driver and the LED frame RAM.
//   rd_row   : one-hot row read address
//   rd_col   : one-hot column read address
//   rd_en    : read address valid
//   led_data : 4-bit pixel, valid one cycle after the address
// master = scan driver side, slave = RAM side.
interface led_scan_driver_if;
  logic [7:0] rd_row;
  logic [7:0] rd_col;
  logic       rd_en;
  logic [3:0] led_data;

  modport master (output rd_row, output rd_col, output rd_en, input led_data);
  modport slave  (input rd_row, input rd_col, input rd_en, output led_data);
endinterface

// File: rtl/led_pwm_line.sv
// Shadow line buffer plus PWM column generator for one matrix row.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear line buffer and PWM counter at the next edge
//   cap_en     : write cap_data into line[cap_idx] at the next edge
//   pwm_adv    : advance pwm_cnt at the next edge (slot boundary)
//   show_nxt   : row will be displayed in the next cycle
//   pwm_cnt    : current PWM slot, 0..15
//   col_drv    : registered column drive, active-high
// Build option: LED_SCAN_GAMMA_EN selects the gamma curve instead of the
// linear pixel-to-level mapping.
module led_pwm_line
  import led_scan_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       cap_en,
  input  logic [2:0] cap_idx,
  input  logic [3:0] cap_data,
  input  logic       pwm_adv,
  input  logic       show_nxt,
  output logic [3:0] pwm_cnt,
  output logic [7:0] col_drv
);

  logic [3:0] line_q [8];
  logic [3:0] line_d [8];
  logic [3:0] pwm_d;
  logic [7:0] col_d;

  function automatic logic [3:0] lvl(input logic [3:0] x);
`ifdef LED_SCAN_GAMMA_EN
    lvl = gamma_lvl(x);
`else
    lvl = x;
`endif
  endfunction

  // col_drv is registered from the next-cycle line/pwm values so that the
  // last pixel captured on the final fetch edge is already visible in the
  // first SHOW cycle.
  always_comb begin
    line_d = line_q;
    pwm_d  = pwm_cnt;
    if (clr) begin
      for (int unsigned i = 0; i < 8; i++) line_d[i] = '0;
      pwm_d = '0;
    end else begin
      if (cap_en)  line_d[cap_idx] = cap_data;
      if (pwm_adv) pwm_d = pwm_cnt + 4'd1;
    end
    col_d = '0;
    if (show_nxt) begin
      for (int unsigned c = 0; c < 8; c++) col_d[c] = (pwm_d < lvl(line_d[c]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) line_q[i] <= '0;
      pwm_cnt <= '0;
      col_drv <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) line_q[i] <= line_d[i];
      pwm_cnt <= pwm_d;
      col_drv <= col_d;
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// LED matrix scan driver: reads one 8-pixel row from the frame RAM, then
// shows it with 16-step PWM, row by row.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : run the scan; low returns to IDLE and clears state
//   ram         : frame RAM read port (rd_row, rd_col, rd_en, led_data)
//   row_drv     : registered one-hot row enable
//   col_drv     : registered column PWM drive
//   scan_row    : row currently fetched or shown
//   frame_start : pulse in the first fetch cycle of row 0
// Parameters: SLOT_CYCLES (clocks per PWM slot), START_ROW (first row).
// Build option: LED_SCAN_GAMMA_EN (gamma brightness curve, see led_pwm_line).
module led_scan_driver
  import led_scan_driver_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned START_ROW   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  led_scan_driver_if.master         ram,
  output logic [7:0]                row_drv,
  output logic [7:0]                col_drv,
  output logic [2:0]                scan_row,
  output logic                      frame_start
);

  localparam int unsigned       SLOT_W     = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [3:0]        FETCH_LAST = 4'(FETCH_CYCLES - 1);
  localparam logic [3:0]        PWM_LAST   = 4'(PWM_STEPS - 1);
  localparam logic [2:0]        ROW_INIT   = 3'(START_ROW);

  scan_state_t       state_q, state_d;
  logic [3:0]        fetch_cnt_q, fetch_cnt_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]        scan_row_d;
  logic [7:0]        row_drv_d;
  logic [3:0]        pwm_cnt;
  logic              clr, cap_en, pwm_adv, show_nxt;
  logic [7:0]        rd_row, rd_col;
  logic              rd_en;

  assign ram.rd_row = rd_row;
  assign ram.rd_col = rd_col;
  assign ram.rd_en  = rd_en;

  always_comb begin
    // Read address and frame marker are decoded from the registered state.
    rd_en       = 1'b0;
    rd_row      = '0;
    rd_col      = '0;
    frame_start = 1'b0;
    if (state_q == FETCH && fetch_cnt_q != FETCH_LAST) begin
      rd_en  = 1'b1;
      rd_row = onehot(scan_row);
      rd_col = onehot(fetch_cnt_q[2:0]);
    end
    if (state_q == FETCH && fetch_cnt_q == '0 && scan_row == '0) frame_start = 1'b1;

    state_d     = state_q;
    fetch_cnt_d = '0;
    slot_cnt_d  = '0;
    scan_row_d  = scan_row;
    clr         = 1'b0;
    cap_en      = 1'b0;
    pwm_adv     = 1'b0;
    if (!enable) begin
      state_d    = IDLE;
      scan_row_d = ROW_INIT;
      clr        = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          // Data for column k-1 arrives while the counter reads k.
          cap_en = (fetch_cnt_q != '0);
          if (fetch_cnt_q == FETCH_LAST) state_d = SHOW;
          else fetch_cnt_d = fetch_cnt_q + 4'd1;
        end
        SHOW: begin
          if (slot_cnt_q == SLOT_LAST) begin
            pwm_adv = 1'b1;
            if (pwm_cnt == PWM_LAST) begin
              state_d    = FETCH;
              scan_row_d = scan_row + 3'd1;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    show_nxt  = (state_d == SHOW);
    row_drv_d = show_nxt ? onehot(scan_row_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_cnt_q <= '0;
      slot_cnt_q  <= '0;
      scan_row    <= ROW_INIT;
      row_drv     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      scan_row    <= scan_row_d;
      row_drv     <= row_drv_d;
    end
  end

  led_pwm_line u_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .cap_en   (cap_en),
    .cap_idx  (3'(fetch_cnt_q - 4'd1)),
    .cap_data (ram.led_data),
    .pwm_adv  (pwm_adv),
    .show_nxt (show_nxt),
    .pwm_cnt  (pwm_cnt),
    .col_drv  (col_drv)
  );

endmodule

// File: tb/tb_led_scan_driver.sv
module tb_led_scan_driver;

  localparam int SLOT = 4;
  localparam int ROWP = 9 + 16 * SLOT;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] row_drv;
  logic [7:0] col_drv;
  logic [2:0] scan_row;
  logic       frame_start;

  led_scan_driver_if ram_if ();

  led_scan_driver #(.SLOT_CYCLES(SLOT), .START_ROW(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ram         (ram_if),
    .row_drv     (row_drv),
    .col_drv     (col_drv),
    .scan_row    (scan_row),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [3:0] mem [8][8];
  int         gam [16] = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 10, 12, 15};
  int         on_cnt [8][8];
  int         fs_cnt;
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic int oh2bin(input logic [7:0] oh);
    int r = 0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic int exp_lvl(input int x);
`ifdef LED_SCAN_GAMMA_EN
    return gam[x];
`else
    return x;
`endif
  endfunction

  // Frame RAM read port: one-cycle registered read.
  always @(posedge clk)
    ram_if.led_data <= ram_if.rd_en ? mem[oh2bin(ram_if.rd_row)][oh2bin(ram_if.rd_col)] : 4'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all_off(input string tag);
    check({tag, "_rd_en"}, 32'(ram_if.rd_en), 0);
    check({tag, "_rd_row"}, 32'(ram_if.rd_row), 0);
    check({tag, "_rd_col"}, 32'(ram_if.rd_col), 0);
    check({tag, "_row_drv"}, 32'(row_drv), 0);
    check({tag, "_col_drv"}, 32'(col_drv), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_scan_row"}, 32'(scan_row), 0);
  endtask

  // Caller sets enable=1 just after a negedge; cycle 1 is the first cycle
  // after the edge that samples it. Expected values from the row timeline.
  task automatic run_scan(input int n);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) on_cnt[r][c] = 0;
    fs_cnt = 0;
    for (int cyc = 1; cyc <= n; cyc++) begin
      int ph, row, slot;
      logic [7:0] e_row, e_col, e_rdr, e_rdc;
      @(negedge clk);
      ph   = (cyc - 1) % ROWP;
      row  = ((cyc - 1) / ROWP) % 8;
      slot = (ph - 9) / SLOT;
      e_row = (ph >= 9) ? 8'(1 << row) : 8'h00;
      e_rdr = (ph < 8) ? 8'(1 << row) : 8'h00;
      e_rdc = (ph < 8) ? 8'(1 << ph) : 8'h00;
      e_col = '0;
      if (ph >= 9) for (int c = 0; c < 8; c++) e_col[c] = (slot < exp_lvl(int'(mem[row][c])));
      check($sformatf("c%0d_rd_en", cyc), 32'(ram_if.rd_en), (ph < 8) ? 1 : 0);
      check($sformatf("c%0d_rd_row", cyc), 32'(ram_if.rd_row), 32'(e_rdr));
      check($sformatf("c%0d_rd_col", cyc), 32'(ram_if.rd_col), 32'(e_rdc));
      check($sformatf("c%0d_frame_start", cyc), 32'(frame_start), (ph == 0 && row == 0) ? 1 : 0);
      check($sformatf("c%0d_scan_row", cyc), 32'(scan_row), 32'(row));
      check($sformatf("c%0d_row_drv", cyc), 32'(row_drv), 32'(e_row));
      check($sformatf("c%0d_col_drv", cyc), 32'(col_drv), 32'(e_col));
      if (frame_start) fs_cnt++;
      if (cyc <= 8 * ROWP)
        for (int c = 0; c < 8; c++) if (col_drv[c]) on_cnt[oh2bin(row_drv)][c]++;
    end
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (r)
          0:       mem[r][c] = 4'(c);
          1:       mem[r][c] = 4'd15;
          2:       mem[r][c] = 4'd0;
          3:       mem[r][c] = 4'd8;
          default: mem[r][c] = 4'((r * 3 + c * 5) & 15);
        endcase

    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_off("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_off("idle");

    // Full frame plus part of the next: row sequence, PWM, frame_start.
    enable = 1'b1;
    run_scan(8 * ROWP + 16);
    check("frame_start_count", 32'(fs_cnt), 2);
    check("row0_col5_on", 32'(on_cnt[0][5]), 32'(exp_lvl(5) * SLOT));
    check("row0_col0_on", 32'(on_cnt[0][0]), 0);
    check("row1_col0_on", 32'(on_cnt[1][0]), 60);
    check("row1_col7_on", 32'(on_cnt[1][7]), 60);
    check("row2_col3_on", 32'(on_cnt[2][3]), 0);
`ifdef LED_SCAN_GAMMA_EN
    check("row3_px8_on", 32'(on_cnt[3][0]), 16);
`else
    check("row3_px8_on", 32'(on_cnt[3][0]), 32);
`endif

    // Drop enable mid-SHOW of row 3, then restart.
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_all_off("drop");
    enable = 1'b1;
    enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_all_off("drop_hold");
    end
    enable = 1'b1;
    run_scan(3 * ROWP + 20);
    enable = 1'b0;
    @(negedge clk);
    check_all_off("drop_row3");
    enable = 1'b1;
    run_scan(ROWP + 7);

    // Asynchronous reset mid-FETCH of row 1 (rd_en currently high).
    check("pre_reset_rd_en", 32'(ram_if.rd_en), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_off("async_rst");
    @(negedge clk);
    check_all_off("in_rst");
    rst_n = 1'b1;
    #1;
    check("post_rst_rd_en", 32'(ram_if.rd_en), 0);
    run_scan(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_scan_driver.md
# led_scan_driver

Display-side reader for the 8×8 LED frame RAM. Walks the matrix one row at a time and issues one-hot row/column read addresses to the RAM. Captures each row's eight 4-bit brightness values into a shadow line buffer, then drives the row and column outputs with 16-step PWM. Sits between the LED RAM read port and the physical matrix pins, alongside the light-pen write path.

## Interface
Parameters:
- SLOT_CYCLES, 4: clk cycles per PWM slot; legal range 1..1023.
- START_ROW, 0: first row scanned after reset or enable; legal range 0..7.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  scan run; low forces IDLE.
- led_data  in  4  RAM read data; valid exactly 1 cycle after rd_row/rd_col are presented.
- rd_row  out  8  one-hot RAM read row address.
- rd_col  out  8  one-hot RAM read column address.
- rd_en  out  1  high while rd_row/rd_col carry a valid read.
- row_drv  out  8  one-hot row enable to the matrix, active-high.
- col_drv  out  8  column PWM drive, active-high.
- scan_row  out  3  binary index of the row currently fetched or shown.
- frame_start  out  1  1-cycle pulse on entry to FETCH of row 0.

## Operation
- FSM states: IDLE, FETCH, SHOW.
- IDLE:
  - All outputs 0; scan_row = START_ROW.
  - enable=1 → FETCH on the next cycle.
- FETCH (9 cycles, k = 0..8):
  - For k = 0..7: rd_row = onehot(scan_row), rd_col = onehot(k), rd_en = 1.
  - For k = 1..8: capture led_data into line[k-1].
  - k = 8: rd_en = 0, rd_row = rd_col = 0.
  - row_drv = col_drv = 0 for the whole state; this doubles as the anti-ghost blanking interval.
  - After k = 8 → SHOW.
- SHOW (16 slots × SLOT_CYCLES cycles):
  - row_drv = onehot(scan_row).
  - col_drv[c] = (pwm_cnt < lvl(line[c])), pwm_cnt = 0..15.
  - Level 0 is always off; level 15 is on for 15 of 16 slots.
  - After the last cycle of slot 15: scan_row ← scan_row+1, wrapping 7→0, then → FETCH.
- frame_start: asserted during FETCH cycle k = 0 when scan_row = 0.
- enable deasserted in any state:
  - Next cycle → IDLE; all drives and reads off.
  - line buffer and counters cleared; scan_row ← START_ROW.
  - A partial row is discarded, never shown.
- enable reasserted while in IDLE: the scan restarts at FETCH of START_ROW.
- RAM writes during FETCH are not blocked here. Pixel-level tearing is accepted; a value is sampled once per row per frame.
- Counter widths: pwm_cnt 4 bits; slot counter ceil(log2(SLOT_CYCLES)) bits, minimum 1; fetch counter 4 bits. All counters are unsigned and roll over only as specified.

## Timing
- Reset value of every output is 0, except scan_row = START_ROW.
- Read latency: 1 cycle, fixed; no handshake, RAM must return data in order.
- Row period: 9 + 16·SLOT_CYCLES cycles (73 at the default).
- Frame period: 8 × row period (584 at the default).
- First rd_en: 1 cycle after enable is sampled high from IDLE.
- First row_drv: 10 cycles after enable is sampled high from IDLE.
- col_drv and row_drv are registered outputs. They change only at slot boundaries and state transitions, never mid-slot.
- row_drv drops to 0 on the same cycle the FSM enters FETCH. No two rows are ever driven in the same cycle.
- Asynchronous reset mid-row takes effect immediately; the FSM returns to IDLE.

## Configuration
- LED_SCAN_GAMMA_EN defined: lvl(x) = GAMMA_LUT[x], with GAMMA_LUT = {0,0,0,1,1,2,2,3,4,5,6,7,9,10,12,15} (index 0..15).
- Undefined: lvl(x) = x, linear.
- Timing, state flow and interface are identical in both builds.

## Structure
- Shared package: FSM state encodings; the PWM_STEPS = 16 and FETCH_CYCLES = 9 constants; GAMMA_LUT; the onehot(bin) encode function.
  - onehot(bin) is the inverse of the binary conversion already used on the write path.
- One sub-module, led_pwm_line: holds the 8 × 4-bit line buffer and pwm_cnt and produces col_drv.
- The top level keeps the FSM, fetch/slot counters and the address outputs.

## Test plan
- Reset, then enable=1 with RAM row 0 = {0,1,…,7} → rd_col steps 01,02,…,80 over cycles 1..8; frame_start pulses in cycle 1; row_drv = 01 from cycle 10.
- Row with all pixels 15, SLOT_CYCLES=4, gamma off → each col_drv bit high for exactly 60 of 64 SHOW cycles; all pixels 0 → col_drv stays 0.
- Scan 8 rows → row_drv sequence 01,02,…,80,01; frame_start every 584 cycles; row_drv = 0 throughout each FETCH.
- Drop enable mid-SHOW of row 3 → next cycle all outputs 0; re-enable → FETCH of row 0 with frame_start.
- Assert rst_n low mid-FETCH → outputs 0 asynchronously; no rd_en until enable is resampled after reset.
- LED_SCAN_GAMMA_EN build with pixel = 8 → col_drv high for 4 of 16 slots; without the macro → 8 of 16 slots.
